// File: rtl/lat_data_memory.sv
// Fixed-latency line memory: one request at a time, completion pulse LATENCY edges after accept.
// Optional byte-strobe writes are enabled by defining LAT_DATA_MEMORY_WSTRB_EN.
module lat_data_memory #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                DDATA_ren,
  input  logic                DDATA_wen,
  input  logic [ADDR_W-1:0]   DDATA_addr,
  input  logic [DATA_W-1:0]   DDATA_wdata,
`ifdef LAT_DATA_MEMORY_WSTRB_EN
  input  logic [DATA_W/8-1:0] DDATA_wstrb,
`endif
  output logic [DATA_W-1:0]   DDATA_rdata,
  output logic                DDATA_ready,
  output logic                DDATA_busy,
  output logic                DDATA_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMP_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept_c, finish_c;
  logic               op_wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
`ifdef LAT_DATA_MEMORY_WSTRB_EN
  logic [STRB_W-1:0]  wstrb_q;
`endif
  logic [DATA_W-1:0]  rdata_q;
  logic               ready_q, busy_q, err_q;
  logic               in_range_c, mem_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [DATA_W-1:0]  rd_line_c;

  logic [DATA_W-1:0]  mem [DEPTH];

  assign in_range_c = (CMP_W'(addr_q) < CMP_W'(DEPTH));
  assign idx_c      = addr_q[IDX_W-1:0];
  assign rd_line_c  = in_range_c ? mem[idx_c] : '0;
  assign mem_we_c   = start_i & finish_c & op_wr_q & in_range_c;

  // Next-state logic; finish_c marks the edge that enters DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (DDATA_ren || DDATA_wen) begin
          accept_c = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 2)) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control, request latches and registered outputs; start_i low freezes everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LAT_DATA_MEMORY_WSTRB_EN
      wstrb_q <= '0;
`endif
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (start_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= finish_c;
      busy_q  <= (state_d != IDLE);
      err_q   <= finish_c & ~in_range_c;
      if (accept_c) begin
        op_wr_q <= DDATA_wen;
        addr_q  <= DDATA_addr;
        wdata_q <= DDATA_wdata;
`ifdef LAT_DATA_MEMORY_WSTRB_EN
        wstrb_q <= DDATA_wstrb;
`endif
      end
      if (finish_c && !op_wr_q) begin
        rdata_q <= rd_line_c;
      end
    end
  end

  // Storage array is never reset; writes land on the edge entering DONE.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
`ifdef LAT_DATA_MEMORY_WSTRB_EN
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) begin
          mem[idx_c][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
`else
      mem[idx_c] <= wdata_q;
`endif
    end
  end

  assign DDATA_rdata = rdata_q;
  assign DDATA_ready = ready_q;
  assign DDATA_busy  = busy_q;
  assign DDATA_err   = err_q;

endmodule
